// File: rtl/light_pkg.sv
// Shared colour codes and helpers for the light selector.
package light_pkg;

  localparam logic [2:0] C_FIRST   = 3'b001;
  localparam logic [2:0] C_LAST    = 3'b110;
  localparam logic [2:0] C_WHITE   = 3'b111;
  localparam int unsigned MAX_CH_W = 32;

  // Step to the next palette code, wrapping C_LAST back to C_FIRST.
  function automatic logic [2:0] next_colour(input logic [2:0] c);
    return (c == C_LAST) ? C_FIRST : c + 3'd1;
  endfunction

  // Expand a {R,G,B} code into a packed word of ch_w bits per channel.
  // Channel k occupies bits [k*ch_w +: ch_w]; only the low 3*ch_w bits are meaningful.
  function automatic logic [3*MAX_CH_W-1:0] code_to_rgb(input logic [2:0] code,
                                                          input int unsigned ch_w);
    logic [3*MAX_CH_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      for (int unsigned i = 0; i < MAX_CH_W; i++) begin
        if (i < ch_w) r[k*ch_w + i] = code[k];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/light_channel_ramp.sv
// One colour channel that slews toward its target by at most STEP per tick.
module light_channel_ramp #(
  parameter int unsigned CH_W = 8,
  parameter int unsigned STEP = 51
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [CH_W-1:0] tgt,
  output logic [CH_W-1:0] cur
);

  localparam logic [CH_W-1:0] STEP_V = CH_W'(STEP);

  logic [CH_W-1:0] up_gap;
  logic [CH_W-1:0] dn_gap;
  logic [CH_W-1:0] up_inc;
  logic [CH_W-1:0] dn_dec;

  // Clamp the step to the remaining distance so the value never overshoots.
  always_comb begin
    up_gap = tgt - cur;
    dn_gap = cur - tgt;
    up_inc = (up_gap > STEP_V) ? STEP_V : up_gap;
    dn_dec = (dn_gap > STEP_V) ? STEP_V : dn_gap;
  end

  // Channel register: white on reset, one clamped move per tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= '1;
    end else if (tick) begin
      if (cur < tgt)      cur <= cur + up_inc;
      else if (cur > tgt) cur <= cur - dn_dec;
    end
  end

endmodule

// File: rtl/light_selector_fade.sv
// White / palette light selector with per-channel linear fading.
module light_selector_fade
  import light_pkg::*;
#(
  parameter int unsigned CH_W     = 8,
  parameter int unsigned STEP     = 51,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned PRE_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic              sel,
  output logic [3*CH_W-1:0] light,
  output logic [2:0]        colour,
  output logic              busy
);

  localparam int unsigned LW = 3 * CH_W;

  logic             btn_q;
  logic             rise;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [LW-1:0]    target;

  assign rise = button & ~btn_q;
  assign tick = (pre_cnt == PRE_W'(PRESCALE - 1));

  // Button history, palette index and free-running ramp prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q   <= 1'b0;
      colour  <= C_FIRST;
      pre_cnt <= '0;
    end else begin
      btn_q   <= button;
      if (rise) colour <= next_colour(colour);
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  // Target colour: white or the expanded palette code.
  always_comb begin
    target = LW'(code_to_rgb(sel ? colour : C_WHITE, CH_W));
  end

  assign busy = (light != target);

  // One independent ramp per channel; channel 2 (R) sits in the top bits.
  for (genvar k = 0; k < 3; k++) begin : g_ch
    light_channel_ramp #(
      .CH_W (CH_W),
      .STEP (STEP)
    ) u_ramp (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .tgt  (target[k*CH_W +: CH_W]),
      .cur  (light[k*CH_W +: CH_W])
    );
  end

endmodule

// File: tb/tb_light_selector_fade.sv
// Directed self-checking bench for light_selector_fade.
module tb_light_selector_fade;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic        rst, button, sel;
  logic [23:0] light;
  logic [2:0]  colour;
  logic        busy;

  // PRESCALE=4, STEP=255 instance.
  logic        rst4, button4, sel4;
  logic [23:0] light4;
  logic [2:0]  colour4;
  logic        busy4;

  light_selector_fade dut (
    .clk(clk), .rst(rst), .button(button), .sel(sel),
    .light(light), .colour(colour), .busy(busy)
  );

  light_selector_fade #(.CH_W(8), .STEP(255), .PRESCALE(4), .PRE_W(16)) dut4 (
    .clk(clk), .rst(rst4), .button(button4), .sel(sel4),
    .light(light4), .colour(colour4), .busy(busy4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        sel;
    logic        button;
    logic [23:0] light;
    logic [2:0]  colour;
    logic        busy;
  } vec_t;

  vec_t        vecs [21];
  logic [2:0]  pulse_exp [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; button = 1'b0; sel = 1'b0;
    rst4 = 1'b1; button4 = 1'b0; sel4 = 1'b0;

    // Reset and idle white
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 24'hFFFFFF, 3'b001, 1'b0};
    for (int i = 1; i <= 5; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 24'hFFFFFF, 3'b001, 1'b0};
    // White -> blue fade, R and G ramp down together
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 24'hCCCCFF, 3'b001, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 24'h9999FF, 3'b001, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 24'h6666FF, 3'b001, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 24'h3333FF, 3'b001, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 24'h0000FF, 3'b001, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 24'h0000FF, 3'b001, 1'b0};
    // Reset, start ramp, redirect back to white mid-ramp
    vecs[12] = '{1'b1, 1'b0, 1'b0, 24'hFFFFFF, 3'b001, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 24'hCCCCFF, 3'b001, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 24'h9999FF, 3'b001, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 24'hCCCCFF, 3'b001, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 24'hFFFFFF, 3'b001, 1'b0};
    // Button and sel in the same cycle, held button, white with advance
    vecs[17] = '{1'b0, 1'b1, 1'b1, 24'hCCCCFF, 3'b010, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 24'h99FFCC, 3'b010, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 24'hCCFFFF, 3'b010, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 1'b1, 24'hFFFFFF, 3'b011, 1'b0};

    pulse_exp = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b001, 3'b010};

    // Table-driven vectors
    for (int i = 0; i < 21; i++) begin
      rst = vecs[i].rst; sel = vecs[i].sel; button = vecs[i].button;
      step();
      check($sformatf("v%0d_light", i),  32'(light),  32'(vecs[i].light));
      check($sformatf("v%0d_colour", i), 32'(colour), 32'(vecs[i].colour));
      check($sformatf("v%0d_busy", i),   32'(busy),   32'(vecs[i].busy));
    end

    // Held button advances once, then single pulses walk and wrap the palette
    rst = 1'b1; sel = 1'b0; button = 1'b0;
    step();
    rst = 1'b0; button = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("held_colour_%0d", i), 32'(colour), 32'(3'b010));
    end
    button = 1'b0;
    step();
    for (int p = 0; p < 6; p++) begin
      button = 1'b1;
      step();
      check($sformatf("pulse_%0d_colour", p), 32'(colour), 32'(pulse_exp[p]));
      button = 1'b0;
      step();
      check($sformatf("pulse_%0d_after", p), 32'(colour), 32'(pulse_exp[p]));
    end

    // Reset mid-ramp with button high; exactly one advance after release
    rst = 1'b1; sel = 1'b0; button = 1'b0;
    step();
    rst = 1'b0; sel = 1'b1;
    step();
    step();
    check("rr_midramp_light", 32'(light), 32'(24'h9999FF));
    rst = 1'b1; button = 1'b1;
    step();
    check("rr_reset_light",  32'(light),  32'(24'hFFFFFF));
    check("rr_reset_colour", 32'(colour), 32'(3'b001));
    check("rr_reset_busy",   32'(busy),   32'(1'b1));
    rst = 1'b0;
    step();
    check("rr_release_colour", 32'(colour), 32'(3'b010));
    check("rr_release_light",  32'(light),  32'(24'hCCCCFF));
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr_hold_colour_%0d", i), 32'(colour), 32'(3'b010));
    end

    // Prescaled one-tick jump on the second instance
    step();
    rst4 = 1'b0; button4 = 1'b1;
    step();
    check("p4_colour",     32'(colour4), 32'(3'b010));
    check("p4_light_init", 32'(light4),  32'(24'hFFFFFF));
    button4 = 1'b0; sel4 = 1'b1;
    step();
    check("p4_busy",        32'(busy4),  32'(1'b1));
    check("p4_hold_a",      32'(light4), 32'(24'hFFFFFF));
    step();
    check("p4_hold_b",      32'(light4), 32'(24'hFFFFFF));
    step();
    check("p4_jump",        32'(light4), 32'(24'h00FF00));
    check("p4_jump_busy",   32'(busy4),  32'(1'b0));
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("p4_steady_%0d", i), 32'(light4), 32'(24'h00FF00));
    end
    sel4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("p4_wait_%0d", i), 32'(light4), 32'(24'h00FF00));
    end
    step();
    check("p4_back_white", 32'(light4), 32'(24'hFFFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
